// File: rtl/mem_stage_param.sv
// MEM stage: byte-addressed data memory with sized, extended loads and
// the MEM/WB register; MEM_LAT > 1 stretches each access and stalls.
// Ports: clk/reset; *_m from EX/MEM; alu_fwd_m, stall_m; *_wb to WB.
module mem_stage_param #(
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 1,
  parameter int REG_W   = 5,
  parameter int PC_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_m,
  input  logic             mem_read_m,
  input  logic             mem_write_m,
  input  logic             mem_to_reg_m,
  input  logic             reg_write_m,
  input  logic             jal_m,
  input  logic [1:0]       size_m,
  input  logic             unsigned_m,
  input  logic [31:0]      alu_result_m,
  input  logic [31:0]      store_data_m,
  input  logic [REG_W-1:0] rd_m,
  input  logic [PC_W-1:0]  pc_m,
  output logic [31:0]      alu_fwd_m,
  output logic             stall_m,
  output logic             valid_wb,
  output logic             mem_to_reg_wb,
  output logic             reg_write_wb,
  output logic             jal_wb,
  output logic [31:0]      load_data_wb,
  output logic [31:0]      alu_result_wb,
  output logic [REG_W-1:0] rd_wb,
  output logic [PC_W-1:0]  pc_wb,
  output logic             misalign_wb
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] widx;
  logic [1:0]        off;
  logic              access;
  logic              misalign;
  logic              retire;
  logic              store_en;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rword;
  logic [31:0]       ldata;

  logic             valid_q, m2r_q, rw_q, jal_q, mis_q;
  logic [31:0]      ld_q, alu_q;
  logic [REG_W-1:0] rd_q;
  logic [PC_W-1:0]  pc_q;

  assign alu_fwd_m = alu_result_m;
  assign widx      = alu_result_m[ADDR_W+1:2];
  assign off       = alu_result_m[1:0];
  assign access    = valid_m & (mem_read_m | mem_write_m);

  always_comb begin
    misalign = 1'b0;
    unique case (size_m)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = off[0];
      default: misalign = |off;
    endcase
    misalign = misalign & access;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    if (MEM_LAT > 1) begin
      unique case (state_q)
        IDLE: begin
          if (access) begin
            state_d   = BUSY;
            lat_cnt_d = CW'(1);
          end
        end
        BUSY: begin
          if (lat_cnt_q == LAST) begin
            state_d   = IDLE;
            lat_cnt_d = '0;
          end else begin
            lat_cnt_d = lat_cnt_q + CW'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          lat_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs: stall until the last latency cycle
  always_comb begin
    stall_m = 1'b0;
    if (MEM_LAT > 1) begin
      unique case (state_q)
        IDLE:    stall_m = access;
        BUSY:    stall_m = (lat_cnt_q != LAST);
        default: stall_m = 1'b0;
      endcase
    end
  end

  assign retire   = ~stall_m;
  assign store_en = access & mem_write_m & ~misalign & retire;

  always_comb begin
    be    = 4'b0000;
    wdata = store_data_m;
    unique case (size_m)
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data_m[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data_m[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data_m;
      end
    endcase
  end

  // Memory is never cleared; reset only blocks a pending write
  always_ff @(posedge clk) begin
    if (!reset && store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rword = mem_q[widx];

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b     = rword[off*8 +: 8];
    h     = off[1] ? rword[31:16] : rword[15:0];
    ldata = rword;
    unique case (size_m)
      2'b00:   ldata = {{24{~unsigned_m & b[7]}}, b};
      2'b01:   ldata = {{16{~unsigned_m & h[15]}}, h};
      default: ldata = rword;
    endcase
    // Simultaneous read+write is a store: no load result
    if (!(access && mem_read_m && !mem_write_m)) ldata = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      jal_q   <= 1'b0;
      mis_q   <= 1'b0;
      ld_q    <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else if (stall_m) begin
      valid_q <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      jal_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      valid_q <= valid_m;
      m2r_q   <= valid_m & mem_to_reg_m;
      rw_q    <= valid_m & reg_write_m & ~misalign;
      jal_q   <= valid_m & jal_m;
      mis_q   <= misalign;
      ld_q    <= ldata;
      alu_q   <= alu_result_m;
      rd_q    <= rd_m;
      pc_q    <= pc_m;
    end
  end

  assign valid_wb      = valid_q;
  assign mem_to_reg_wb = m2r_q;
  assign reg_write_wb  = rw_q;
  assign jal_wb        = jal_q;
  assign misalign_wb   = mis_q;
  assign load_data_wb  = ld_q;
  assign alu_result_wb = alu_q;
  assign rd_wb         = rd_q;
  assign pc_wb         = pc_q;

endmodule

// File: tb/tb_mem_stage_param.sv
// Directed bench for mem_stage_param at MEM_LAT=1 (dut a)
// and MEM_LAT=3 (dut b).
module tb_mem_stage_param;

  typedef struct packed {
    logic        valid;
    logic        rd_en;
    logic        wr_en;
    logic        m2r;
    logic        rw;
    logic        jal;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] pc;
  } in_t;

  typedef struct packed {
    logic [31:0] fwd;
    logic        stall;
    logic        valid;
    logic        m2r;
    logic        rw;
    logic        jal;
    logic [31:0] ld;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        mis;
  } out_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  in_t  ia, ib;
  out_t oa, ob;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage_param #(.MEM_LAT(1)) u_a (
    .clk(clk), .reset(rst_a),
    .valid_m(ia.valid), .mem_read_m(ia.rd_en),
    .mem_write_m(ia.wr_en), .mem_to_reg_m(ia.m2r),
    .reg_write_m(ia.rw), .jal_m(ia.jal),
    .size_m(ia.size), .unsigned_m(ia.uns),
    .alu_result_m(ia.addr), .store_data_m(ia.sd),
    .rd_m(ia.rd), .pc_m(ia.pc),
    .alu_fwd_m(oa.fwd), .stall_m(oa.stall),
    .valid_wb(oa.valid), .mem_to_reg_wb(oa.m2r),
    .reg_write_wb(oa.rw), .jal_wb(oa.jal),
    .load_data_wb(oa.ld), .alu_result_wb(oa.alu),
    .rd_wb(oa.rd), .pc_wb(oa.pc),
    .misalign_wb(oa.mis)
  );

  mem_stage_param #(.MEM_LAT(3)) u_b (
    .clk(clk), .reset(rst_b),
    .valid_m(ib.valid), .mem_read_m(ib.rd_en),
    .mem_write_m(ib.wr_en), .mem_to_reg_m(ib.m2r),
    .reg_write_m(ib.rw), .jal_m(ib.jal),
    .size_m(ib.size), .unsigned_m(ib.uns),
    .alu_result_m(ib.addr), .store_data_m(ib.sd),
    .rd_m(ib.rd), .pc_m(ib.pc),
    .alu_fwd_m(ob.fwd), .stall_m(ob.stall),
    .valid_wb(ob.valid), .mem_to_reg_wb(ob.m2r),
    .reg_write_wb(ob.rw), .jal_wb(ob.jal),
    .load_data_wb(ob.ld), .alu_result_wb(ob.alu),
    .rd_wb(ob.rd), .pc_wb(ob.pc),
    .misalign_wb(ob.mis)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic in_t mop(input bit rd, input bit wr,
                              input logic [1:0] sz,
                              input bit uns,
                              input logic [31:0] addr,
                              input logic [31:0] sd);
    in_t x;
    x       = '0;
    x.valid = 1'b1;
    x.rd_en = rd;
    x.wr_en = wr;
    x.m2r   = rd;
    x.rw    = rd;
    x.size  = sz;
    x.uns   = uns;
    x.addr  = addr;
    x.sd    = sd;
    x.rd    = 5'd3;
    return x;
  endfunction

  // Single-cycle op on dut a: stall must stay low
  task automatic run_a(input in_t x);
    ia = x;
    #1;
    if (x.valid && x.rd_en && !x.wr_en && x.addr == 32'h8)
      chk("a_stall", {31'b0, oa.stall}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Multi-cycle op on dut b with expected stall count
  task automatic run_b(input string tag, input in_t x,
                       input int stalls);
    ib = x;
    for (int i = 0; i < stalls; i++) begin
      #1;
      chk({tag, "_stall1"}, {31'b0, ob.stall}, 32'h1);
      @(posedge clk);
      #1;
      chk({tag, "_bubble"}, {31'b0, ob.valid}, 32'h0);
    end
    #1;
    chk({tag, "_stall0"}, {31'b0, ob.stall}, 32'h0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {31'b0, ob.valid}, 32'h1);
  endtask

  initial begin
    in_t j;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia    = '0;
    ib    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk("rst_valid", {31'b0, oa.valid}, 32'h0);
    chk("rst_ld", oa.ld, 32'h0);
    chk("rst_pc", oa.pc, 32'h0);
    chk("rst_b_stall", {31'b0, ob.stall}, 32'h0);

    // MEM_LAT=1
    run_a(mop(0, 1, 2'b10, 0, 32'h8, 32'hDEADBEEF));
    chk("sw_valid", {31'b0, oa.valid}, 32'h1);
    chk("sw_rw", {31'b0, oa.rw}, 32'h0);
    run_a(mop(1, 0, 2'b10, 0, 32'h8, 32'h0));
    chk("lw8", oa.ld, 32'hDEADBEEF);
    chk("lw8_m2r", {31'b0, oa.m2r}, 32'h1);
    chk("lw8_rw", {31'b0, oa.rw}, 32'h1);
    run_a(mop(0, 1, 2'b00, 0, 32'h9, 32'h00000080));
    run_a(mop(1, 0, 2'b10, 0, 32'h8, 32'h0));
    chk("sb_word", oa.ld, 32'hDEAD80EF);
    run_a(mop(1, 0, 2'b00, 0, 32'h9, 32'h0));
    chk("lb9", oa.ld, 32'hFFFFFF80);
    run_a(mop(1, 0, 2'b00, 1, 32'h9, 32'h0));
    chk("lbu9", oa.ld, 32'h00000080);
    run_a(mop(0, 1, 2'b01, 0, 32'hA, 32'h00001234));
    run_a(mop(1, 0, 2'b01, 0, 32'hA, 32'h0));
    chk("lhA", oa.ld, 32'h00001234);
    run_a(mop(1, 0, 2'b01, 0, 32'hB, 32'h0));
    chk("lhB_mis", {31'b0, oa.mis}, 32'h1);
    chk("lhB_rw", {31'b0, oa.rw}, 32'h0);
    run_a(mop(0, 1, 2'b01, 0, 32'hB, 32'h0000FFFF));
    chk("shB_mis", {31'b0, oa.mis}, 32'h1);
    run_a(mop(0, 1, 2'b10, 0, 32'h9, 32'h55555555));
    run_a(mop(1, 0, 2'b10, 0, 32'h8, 32'h0));
    chk("mis_nowr", oa.ld, 32'h123480EF);
    chk("mis_clr", {31'b0, oa.mis}, 32'h0);
    j       = '0;
    j.valid = 1'b1;
    j.jal   = 1'b1;
    j.rw    = 1'b1;
    j.rd    = 5'd31;
    j.pc    = 32'h40;
    j.addr  = 32'h44;
    run_a(j);
    chk("jal", {31'b0, oa.jal}, 32'h1);
    chk("jal_pc", oa.pc, 32'h40);
    chk("jal_rd", {27'b0, oa.rd}, 32'd31);
    chk("jal_alu", oa.alu, 32'h44);
    run_a(mop(0, 1, 2'b10, 0, 32'h80, 32'h11223344));
    run_a(mop(1, 0, 2'b10, 0, 32'h0, 32'h0));
    chk("wrap", oa.ld, 32'h11223344);
    run_a(mop(1, 1, 2'b10, 0, 32'h4, 32'hAAAA5555));
    chk("rw_both_ld", oa.ld, 32'h0);
    run_a(mop(1, 0, 2'b10, 0, 32'h4, 32'h0));
    chk("rw_both_st", oa.ld, 32'hAAAA5555);
    j       = mop(1, 0, 2'b10, 0, 32'h8, 32'h0);
    j.valid = 1'b0;
    run_a(j);
    chk("inv_valid", {31'b0, oa.valid}, 32'h0);
    chk("inv_rw", {31'b0, oa.rw}, 32'h0);
    chk("inv_m2r", {31'b0, oa.m2r}, 32'h0);

    // MEM_LAT=3
    run_b("bsw", mop(0, 1, 2'b10, 0, 32'h10, 32'hCAFEF00D), 2);
    run_b("blw", mop(1, 0, 2'b10, 0, 32'h10, 32'h0), 2);
    chk("blw_data", ob.ld, 32'hCAFEF00D);
    j      = '0;
    j.valid = 1'b1;
    j.rw   = 1'b1;
    j.addr = 32'h1234;
    run_b("balu", j, 0);
    chk("balu_res", ob.alu, 32'h1234);
    chk("balu_fwd", ob.fwd, 32'h1234);
    ib = mop(0, 1, 2'b10, 0, 32'h10, 32'h12345678);
    #1;
    chk("brst_stall1", {31'b0, ob.stall}, 32'h1);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    ib    = '0;
    chk("brst_valid", {31'b0, ob.valid}, 32'h0);
    chk("brst_alu", ob.alu, 32'h0);
    chk("brst_pc", ob.pc, 32'h0);
    #1;
    chk("brst_stall0", {31'b0, ob.stall}, 32'h0);
    @(posedge clk);
    #1;
    run_b("blw2", mop(1, 0, 2'b10, 0, 32'h10, 32'h0), 2);
    chk("brst_nowr", ob.ld, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
